imm_rot_encoder: RTL and testbench
==================================

// Module: imm_rot_encoder
// PURPOSE
//  Iterative encoder for data-processing immediates: given a 32-bit constant, finds
//  imm8/rotation_code such that ROR(imm8, 2*rotation_code) == constant. It is the
//  inverse of the shifter's immediate path (in_data_imm, rotation_code) and feeds
//  the decode/test infrastructure that builds operand2 fields.
//  Tests one rotation per cycle under a start/busy/done handshake.
// PARAMETERS
//  ALLOW_INV  1  1: when the direct value fails, also test ~in_value (MVN/BIC form).
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   asynchronous, active-high reset
//  start          in   1   request; sampled only when busy=0
//  in_value       in   32  constant to encode; latched when start is accepted
//  busy           out  1   search in progress
//  done           out  1   one-cycle pulse: result fields valid from this cycle
//  encodable      out  1   1 = a valid encoding was found
//  inverted       out  1   1 = encoding is for ~in_value (always 0 if ALLOW_INV=0)
//  imm8           out  8   immediate field
//  rotation_code  out  4   rotation field; effective right-rotate = 2*rotation_code
//  rot_amt        out  5   2*rotation_code, for the shifter's shift_amt ports
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, counter r=0, all outputs 0. Search in
//    progress is abandoned; no done pulse follows.
//  - FSM IDLE -> SEARCH on start&&!busy at edge E0: latch in_value, set r=0, busy=1.
//  - SEARCH cycle k tests r=k: cand=ROL(val,2r); hit if cand[31:8]==0.
//    If ALLOW_INV: cand_n=ROL(~val,2r) is tested in the same cycle.
//    Priority: direct hit over inverted hit; smallest r wins (first hit ends search).
//  - On hit at r: at edge E(r+1) register imm8=cand[7:0] (or cand_n[7:0]),
//    rotation_code=r, rot_amt=2r, encodable=1, inverted as applicable; done=1,
//    busy=0, state->IDLE. Latency: r+1 cycles (value 0 -> 1 cycle, r=0).
//  - Miss at r=15: at E16 done=1, encodable=0, inverted=0, imm8=0, rotation_code=0.
//  - Result fields hold until the next done; done is high for exactly one cycle.
//  - start while busy: ignored (not queued). start in the done cycle: accepted
//    (busy=0 then); the new search begins and the previous result stays visible.
//  - r counts 0..15 only; it never wraps during a search.
//  - Rotations are pure wiring plus a 16-way mux on r; no multi-cycle arithmetic.
// STRUCTURE
//  - Shared package/header: ROT_W=4, IMM_W=8, DATA_W=32, FSM state encodings
//    (IDLE, SEARCH), and a rol32(val, amt) function also used by the shifter bench.
//  - One natural sub-module: imm_fit_check (combinational: val, r -> hit, imm8),
//    instantiated twice when ALLOW_INV=1.
//  - Top holds the FSM, r counter, value latch and output registers.
// TESTING
//  - 0x000000FF -> done at E1, encodable=1, imm8=FF, rotation_code=0, inverted=0.
//  - 0xFF000000 -> done at E5, imm8=FF, rotation_code=4, rot_amt=8.
//  - 0x80000009 -> done at E2, imm8=26, rotation_code=1; imm8 driven through the
//    shifter with rot_amt=2 must return 0x80000009.
//  - 0xFFFFFF00 (ALLOW_INV=1) -> done at E1, inverted=1, imm8=FF, rotation_code=0;
//    with ALLOW_INV=0 -> done at E16, encodable=0.
//  - 0x00000102 -> busy for 16 cycles, done at E16, encodable=0; start pulses
//    during busy are ignored (exactly one done).
//  - start 0x00000102, reset at E5 -> busy=0, all outputs 0, no done; next start
//    0x000000FF completes normally at E1.

Source files
------------

// File: rtl/imm_rot_encoder_pkg.sv
// Shared definitions for the immediate/rotation encoder and the shifter bench.
//   ROT_W / IMM_W / DATA_W : field widths of the operand2 immediate form
//   AMT_W                  : width of an effective rotate amount (2*rotation_code)
//   state_t                : encoder FSM states
//   rol32()                : 32-bit rotate-left by 0..31
package imm_rot_encoder_pkg;

  localparam int ROT_W  = 4;
  localparam int IMM_W  = 8;
  localparam int DATA_W = 32;
  localparam int AMT_W  = ROT_W + 1;

  // Last rotation tested before the search gives up.
  localparam logic [ROT_W-1:0] ROT_MAX = '1;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  // Rotate left: the upper half of the doubled word shifted left is the
  // rotated value, so amt=0 needs no special case.
  function automatic logic [DATA_W-1:0] rol32(input logic [DATA_W-1:0] val,
                                              input logic [AMT_W-1:0]  amt);
    logic [2*DATA_W-1:0] dbl;
    dbl = {val, val} << amt;
    return dbl[2*DATA_W-1:DATA_W];
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// Combinational fit test for one rotation code.
//   val  : 32-bit value under test
//   r    : rotation code; the value is rotated left by 2*r
//   hit  : 1 when the rotated value fits entirely in the low 8 bits
//   imm8 : low 8 bits of the rotated value (the immediate when hit=1)
module imm_fit_check
  import imm_rot_encoder_pkg::*;
(
  input  logic [DATA_W-1:0] val,
  input  logic [ROT_W-1:0]  r,
  output logic              hit,
  output logic [IMM_W-1:0]  imm8
);

  logic [DATA_W-1:0] cand;

  // ROR(imm8, 2r) == val  <=>  ROL(val, 2r) has nothing above bit 7.
  assign cand = rol32(val, {r, 1'b0});
  assign hit  = (cand[DATA_W-1:IMM_W] == '0);
  assign imm8 = cand[IMM_W-1:0];

endmodule

// File: rtl/imm_rot_encoder.sv
// Iterative operand2 immediate encoder: finds imm8/rotation_code such that
// ROR(imm8, 2*rotation_code) equals the requested constant (or its complement
// when ALLOW_INV=1), testing one rotation per cycle.
//   clk, reset      : clock (rising edge), asynchronous active-high reset
//   start, in_value : request and constant to encode
//   busy, done      : search in progress / one-cycle result pulse
//   encodable, inverted, imm8, rotation_code, rot_amt : result fields
//   state_dbg       : current FSM state, for observation only
//
// Handshake: start is sampled only while busy=0; the edge that accepts it
// latches in_value and raises busy. Starts seen while busy=1 are dropped.
// done pulses for exactly one cycle with busy=0, and the result fields are
// valid from that cycle until the next done. A start in the done cycle is
// accepted and the previous result remains visible while the new search runs.
module imm_rot_encoder
  import imm_rot_encoder_pkg::*;
#(
  parameter int unsigned ALLOW_INV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] in_value,
  output logic              busy,
  output logic              done,
  output logic              encodable,
  output logic              inverted,
  output logic [IMM_W-1:0]  imm8,
  output logic [ROT_W-1:0]  rotation_code,
  output logic [AMT_W-1:0]  rot_amt,
  output state_t            state_dbg
);

  state_t             state_q, state_d;
  logic [ROT_W-1:0]   r_q, r_d;
  logic [DATA_W-1:0]  val_q, val_d;
  logic               done_d, enc_d, inv_d;
  logic [IMM_W-1:0]   imm_d;
  logic [ROT_W-1:0]   rot_d;

  logic               hit_dir, hit_inv;
  logic [IMM_W-1:0]   imm_dir, imm_inv;

  imm_fit_check u_fit_dir (
    .val  (val_q),
    .r    (r_q),
    .hit  (hit_dir),
    .imm8 (imm_dir)
  );

  generate
    if (ALLOW_INV != 0) begin : g_inv
      imm_fit_check u_fit_inv (
        .val  (~val_q),
        .r    (r_q),
        .hit  (hit_inv),
        .imm8 (imm_inv)
      );
    end else begin : g_no_inv
      assign hit_inv = 1'b0;
      assign imm_inv = '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    val_d   = val_q;
    done_d  = 1'b0;
    enc_d   = encodable;
    inv_d   = inverted;
    imm_d   = imm8;
    rot_d   = rotation_code;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEARCH;
          r_d     = '0;
          val_d   = in_value;
        end
      end
      SEARCH: begin
        // The first hit ends the search, so the smallest rotation wins and a
        // direct hit beats an inverted hit at the same rotation.
        if (hit_dir || hit_inv || (r_q == ROT_MAX)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          enc_d   = hit_dir || hit_inv;
          inv_d   = !hit_dir && hit_inv;
          imm_d   = hit_dir ? imm_dir : (hit_inv ? imm_inv : '0);
          rot_d   = (hit_dir || hit_inv) ? r_q : '0;
        end else begin
          r_d = r_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      r_q           <= '0;
      val_q         <= '0;
      done          <= 1'b0;
      encodable     <= 1'b0;
      inverted      <= 1'b0;
      imm8          <= '0;
      rotation_code <= '0;
    end else begin
      state_q       <= state_d;
      r_q           <= r_d;
      val_q         <= val_d;
      done          <= done_d;
      encodable     <= enc_d;
      inverted      <= inv_d;
      imm8          <= imm_d;
      rotation_code <= rot_d;
    end
  end

  assign busy      = (state_q == SEARCH);
  assign rot_amt   = {rotation_code, 1'b0};
  assign state_dbg = state_q;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Bench for imm_rot_encoder: one instance with ALLOW_INV=1 (main) and one with
// ALLOW_INV=0. Expected results are queued at launch and popped on done.
// Expected word layout: [18] encodable [17] inverted [16:9] imm8
//                       [8:5] rotation_code [4:0] done latency in cycles.
module tb_imm_rot_encoder;
  import imm_rot_encoder_pkg::*;

  localparam int W = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        start1 = 1'b0, start0 = 1'b0;
  logic [31:0] in_value = '0;

  logic        busy1, done1, enc1, inv1;
  logic [7:0]  imm1;
  logic [3:0]  rot1;
  logic [4:0]  amt1;
  state_t      st1;
  logic        busy0, done0, enc0, inv0;
  logic [7:0]  imm0;
  logic [3:0]  rot0;
  logic [4:0]  amt0;
  state_t      st0;

  imm_rot_encoder #(.ALLOW_INV(1)) dut (
    .clk(clk), .reset(reset), .start(start1), .in_value(in_value),
    .busy(busy1), .done(done1), .encodable(enc1), .inverted(inv1),
    .imm8(imm1), .rotation_code(rot1), .rot_amt(amt1), .state_dbg(st1)
  );

  imm_rot_encoder #(.ALLOW_INV(0)) dut_noinv (
    .clk(clk), .reset(reset), .start(start0), .in_value(in_value),
    .busy(busy0), .done(done0), .encodable(enc0), .inverted(inv0),
    .imm8(imm0), .rotation_code(rot0), .rot_amt(amt0), .state_dbg(st0)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [31:0] tb_rol(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [31:0] tb_ror(input logic [31:0] v, input int s);
    if (s == 0) return v;
    return (v >> s) | (v << (32 - s));
  endfunction

  function automatic logic [W-1:0] mk(input bit enc, input bit inv, input logic [7:0] imm,
                                      input logic [3:0] rot, input logic [4:0] lat);
    return {enc, inv, imm, rot, lat};
  endfunction

  // Reference search over all 16 rotations, smallest rotation first.
  function automatic logic [W-1:0] model(input logic [31:0] v, input bit allow_inv);
    logic [31:0] c, cn;
    for (int r = 0; r < 16; r++) begin
      c  = tb_rol(v, 2 * r);
      cn = tb_rol(~v, 2 * r);
      if (c[31:8] == 24'h0) return mk(1'b1, 1'b0, c[7:0], 4'(r), 5'(r + 1));
      if (allow_inv && cn[31:8] == 24'h0) return mk(1'b1, 1'b1, cn[7:0], 4'(r), 5'(r + 1));
    end
    return mk(1'b0, 1'b0, 8'h00, 4'h0, 5'd16);
  endfunction

  function automatic logic [13:0] obs_res(input bit sel);
    return sel ? {enc1, inv1, imm1, rot1} : {enc0, inv0, imm0, rot0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Drives start for one edge (E0) and queues the expected result.
  task automatic launch(input bit sel, input logic [31:0] v, input logic [W-1:0] e);
    in_value = v;
    if (sel) start1 = 1'b1;
    else     start0 = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
    check("busy_after_accept", sel ? busy1 : busy0, 1);
  endtask

  // Waits (bounded) for done, measuring latency from E0, then scores it.
  // With inject=1, random start pulses are thrown at the busy main instance.
  task automatic wait_result(input bit sel, input bit inject, input logic [31:0] v,
                             input string tag);
    logic [W-1:0] e;
    logic [13:0]  o;
    logic [4:0]   amt;
    int           lat;
    bit           seen;
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      start0 = 1'b0;
      if (sel ? done1 : done0) begin
        seen = 1'b1;
        lat  = k;
      end else if (inject && busy1) begin
        in_value = $urandom;
        start1   = 1'($urandom_range(0, 1));
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
    check({tag, "_queue_nonempty"}, 32'(exp_q.size() > 0), 1);
    if (seen && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      o   = obs_res(sel);
      amt = sel ? amt1 : amt0;
      check({tag, "_result"}, {o, 5'(lat)}, e);
      check({tag, "_rot_amt"}, amt, {e[8:5], 1'b0});
      check({tag, "_busy_at_done"}, sel ? busy1 : busy0, 0);
      if (o[13])
        check({tag, "_shifter"}, tb_ror({24'h0, o[11:4]}, int'(amt)), o[12] ? ~v : v);
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] v;
  logic [W-1:0] e;
  int extra_done;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_res1", obs_res(1), 0);
    check("reset_res0", obs_res(0), 0);
    check("reset_amt", amt1, 0);
    check("reset_busy_done", {busy1, done1, busy0, done0}, 0);
    check("reset_state", st1, IDLE);
    reset = 1'b0;
    @(posedge clk); #1;

    // Already fits: r=0.
    launch(1, 32'h0000_00FF, mk(1, 0, 8'hFF, 4'd0, 5'd1));
    wait_result(1, 0, 32'h0000_00FF, "ff");
    @(posedge clk); #1;
    check("done_one_cycle", done1, 0);
    check("result_held", obs_res(1), {2'b10, 8'hFF, 4'd0});

    launch(1, 32'hFF00_0000, mk(1, 0, 8'hFF, 4'd4, 5'd5));
    wait_result(1, 0, 32'hFF00_0000, "ff000000");

    launch(1, 32'h8000_0009, mk(1, 0, 8'h26, 4'd1, 5'd2));
    wait_result(1, 0, 32'h8000_0009, "80000009");
    // Start in the done cycle; previous result stays visible during the search.
    launch(1, 32'h0000_03FC, mk(1, 0, 8'hFF, 4'd15, 5'd16));
    check("chain_prev_visible", obs_res(1), {2'b10, 8'h26, 4'd1});
    wait_result(1, 0, 32'h0000_03FC, "3fc_last_rot");

    // Complement form, with and without ALLOW_INV.
    launch(1, 32'hFFFF_FF00, mk(1, 1, 8'hFF, 4'd0, 5'd1));
    wait_result(1, 0, 32'hFFFF_FF00, "inv_allowed");
    launch(0, 32'hFFFF_FF00, mk(0, 0, 8'h00, 4'd0, 5'd16));
    wait_result(0, 0, 32'hFFFF_FF00, "inv_blocked");

    // Random encodable (possibly complemented) and raw random values.
    for (int i = 0; i < 6; i++) begin
      v = tb_ror({24'h0, 8'($urandom_range(1, 255))}, 2 * $urandom_range(0, 15));
      if (i % 3 == 1) v = ~v;
      if (i % 3 == 2) v = $urandom;
      launch(1, v, model(v, 1'b1));
      wait_result(1, 0, v, "random");
    end

    // Unencodable with start pulses thrown in while busy.
    launch(1, 32'h0000_0102, mk(0, 0, 8'h00, 4'd0, 5'd16));
    wait_result(1, 1, 32'h0000_0102, "unenc_102");
    extra_done = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done1) extra_done++;
    end
    check("single_done_102", extra_done, 0);
    check("idle_after_102", busy1, 0);

    // Leave a nonzero result, then reset in the middle of a search.
    launch(1, 32'hFF00_0000, mk(1, 0, 8'hFF, 4'd4, 5'd5));
    wait_result(1, 0, 32'hFF00_0000, "pre_reset");
    launch(1, 32'h0000_0102, mk(0, 0, 8'h00, 4'd0, 5'd16));
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("midreset_res", obs_res(1), 0);
    check("midreset_amt", amt1, 0);
    check("midreset_busy_done", {busy1, done1}, 0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    extra_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done1 || busy1) extra_done++;
    end
    check("no_done_after_reset", extra_done, 0);

    launch(1, 32'h0000_00FF, mk(1, 0, 8'hFF, 4'd0, 5'd1));
    wait_result(1, 0, 32'h0000_00FF, "after_reset");

    check("queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
